spi_block_sequencer: RTL and testbench

- Hardware sequencer for the SPI shifter that performs a complete SD data-block read with no per-byte CPU involvement.
- Polls for the start token with a timeout, then reads BLOCK_LEN data bytes into a small FIFO that the bus side drains.
- Reads the two trailing CRC bytes and checks them against the shifter's running CRC.
- Sits between the bus register decoder and the shifter, in parallel with the existing CPU-driven start_read path; the decoder muxes the two start_read sources.

---
 rtl/spi_block_sequencer.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_spi_block_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_block_sequencer.sv
// spi_block_sequencer
// Runs a complete SD data-block read on the SPI shifter: polls for the
// 0xFE start token, streams BLOCK_LEN data bytes into a small first-word
// fall-through FIFO drained by the bus side, then reads the two trailing
// CRC bytes and compares them with the shifter's running CRC16 snapshot.
//
// state        | meaning
// -------------+------------------------------------------------------------
// S_IDLE       | waiting for go; FIFO may still hold bytes of the last block
// S_TOKEN_*    | one 0xFF poll byte transaction looking for the 0xFE token
// S_DATA_*     | one data byte transaction; START stalls while FIFO is full
// S_CRCH_*     | receive CRC high byte
// S_CRCL_*     | receive CRC low byte
// S_CHECK      | compare received CRC with the snapshot, set done/crc_err
//
// Every byte transaction is START -> ARM -> WAIT:
//   START issues shf_start_read (seen by the shifter during ARM),
//   ARM lets the shifter raise busy, WAIT captures shf_data once busy drops.

module spi_block_sequencer #(
    parameter int BLOCK_LEN     = 512,
    parameter int FIFO_DEPTH    = 4,
    parameter int TOKEN_TIMEOUT = 4095
) (
    input  logic        clk7,
    input  logic        rst,
    input  logic        go,
    input  logic        abort,
    output logic        shf_start_read,
    input  logic        shf_busy,
    input  logic [7:0]  shf_data,
    output logic        shf_crc_reset,
    input  logic [15:0] shf_crc,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        rd_ack,
    output logic        seq_busy,
    output logic        done,
    output logic        crc_err,
    output logic        token_err,
    output logic        timeout_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [12:0]      LAST_BYTE  = 13'(BLOCK_LEN);
    localparam logic [11:0]      POLL_LIMIT = 12'(TOKEN_TIMEOUT);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [3:0] {
        S_IDLE,
        S_TOKEN_START,
        S_TOKEN_ARM,
        S_TOKEN_WAIT,
        S_DATA_START,
        S_DATA_ARM,
        S_DATA_WAIT,
        S_CRCH_START,
        S_CRCH_ARM,
        S_CRCH_WAIT,
        S_CRCL_START,
        S_CRCL_ARM,
        S_CRCL_WAIT,
        S_CHECK
    } state_t;

    state_t      state;
    logic [11:0] poll_cnt;
    logic [12:0] byte_cnt;
    logic [15:0] crc_snap;
    logic [15:0] crc_rx;
    logic        abort_hold;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             is_start;
    logic             is_arm;
    logic             is_wait;
    logic             drop;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             flush;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic [7:0]       head_nxt;

    function automatic state_t arm_of(input state_t s);
        case (s)
            S_TOKEN_START: return S_TOKEN_ARM;
            S_DATA_START:  return S_DATA_ARM;
            S_CRCH_START:  return S_CRCH_ARM;
            S_CRCL_START:  return S_CRCL_ARM;
            default:       return S_IDLE;
        endcase
    endfunction

    function automatic state_t wait_of(input state_t s);
        case (s)
            S_TOKEN_ARM: return S_TOKEN_WAIT;
            S_DATA_ARM:  return S_DATA_WAIT;
            S_CRCH_ARM:  return S_CRCH_WAIT;
            S_CRCL_ARM:  return S_CRCL_WAIT;
            default:     return S_IDLE;
        endcase
    endfunction

    // State-class decode, FIFO push/pop qualification and next-head lookup.
    // The push is combinational from the capture cycle so the FIFO count is
    // already current when the FSM re-enters DATA_START and tests for full.
    always_comb begin
        is_start = (state == S_TOKEN_START) || (state == S_DATA_START) ||
                   (state == S_CRCH_START)  || (state == S_CRCL_START);
        is_arm   = (state == S_TOKEN_ARM)   || (state == S_DATA_ARM) ||
                   (state == S_CRCH_ARM)    || (state == S_CRCL_ARM);
        is_wait  = (state == S_TOKEN_WAIT)  || (state == S_DATA_WAIT) ||
                   (state == S_CRCH_WAIT)   || (state == S_CRCL_WAIT);
        drop      = abort || abort_hold;
        fifo_full = (count == FULL_CNT);
        push      = (state == S_DATA_WAIT) && !shf_busy && !drop;
        pop       = rd_ack && rd_valid;
        flush     = (state == S_IDLE) && go;
        rd_ptr_nxt = rd_ptr + PTR_W'(pop);
        count_nxt  = count + CNT_W'(push) - CNT_W'(pop);
        // A byte pushed into the slot that becomes the head must bypass mem.
        if (push && (wr_ptr == rd_ptr_nxt)) begin
            head_nxt = shf_data;
        end else begin
            head_nxt = mem[rd_ptr_nxt];
        end
    end

    // Sequencer FSM with registered strobes, sticky flags and counters.
    always_ff @(posedge clk7 or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            poll_cnt       <= '0;
            byte_cnt       <= '0;
            crc_snap       <= '0;
            crc_rx         <= '0;
            abort_hold     <= 1'b0;
            shf_start_read <= 1'b0;
            shf_crc_reset  <= 1'b0;
            seq_busy       <= 1'b0;
            done           <= 1'b0;
            crc_err        <= 1'b0;
            token_err      <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            shf_start_read <= 1'b0;
            shf_crc_reset  <= 1'b0;

            if (state == S_IDLE) begin
                // go beats a simultaneous abort here: abort is only looked at
                // once the sequence is running.
                if (go) begin
                    done        <= 1'b0;
                    crc_err     <= 1'b0;
                    token_err   <= 1'b0;
                    timeout_err <= 1'b0;
                    poll_cnt    <= '0;
                    byte_cnt    <= '0;
                    crc_snap    <= '0;
                    crc_rx      <= '0;
                    abort_hold  <= 1'b0;
                    seq_busy    <= 1'b1;
                    state       <= S_TOKEN_START;
                end
            end else if (is_start) begin
                // No byte is in flight yet, so abort can leave at once.
                if (abort) begin
                    seq_busy   <= 1'b0;
                    abort_hold <= 1'b0;
                    state      <= S_IDLE;
                end else if (!shf_busy && ((state != S_DATA_START) || !fifo_full)) begin
                    shf_start_read <= 1'b1;
                    state          <= arm_of(state);
                end
            end else if (is_arm) begin
                if (abort) begin
                    abort_hold <= 1'b1;
                end
                state <= wait_of(state);
            end else if (is_wait) begin
                if (shf_busy) begin
                    if (abort) begin
                        abort_hold <= 1'b1;
                    end
                end else if (drop) begin
                    // Byte finished on the wire but is thrown away.
                    seq_busy   <= 1'b0;
                    abort_hold <= 1'b0;
                    state      <= S_IDLE;
                end else begin
                    case (state)
                        S_TOKEN_WAIT: begin
                            if (shf_data == 8'hFE) begin
                                shf_crc_reset <= 1'b1;
                                state         <= S_DATA_START;
                            end else if (shf_data == 8'hFF) begin
                                poll_cnt <= poll_cnt + 12'd1;
                                if (poll_cnt + 12'd1 == POLL_LIMIT) begin
                                    timeout_err <= 1'b1;
                                    seq_busy    <= 1'b0;
                                    state       <= S_IDLE;
                                end else begin
                                    state <= S_TOKEN_START;
                                end
                            end else begin
                                token_err <= 1'b1;
                                seq_busy  <= 1'b0;
                                state     <= S_IDLE;
                            end
                        end
                        S_DATA_WAIT: begin
                            byte_cnt <= byte_cnt + 13'd1;
                            if (byte_cnt + 13'd1 == LAST_BYTE) begin
                                // shf_crc now covers exactly the data bytes.
                                crc_snap <= shf_crc;
                                state    <= S_CRCH_START;
                            end else begin
                                state <= S_DATA_START;
                            end
                        end
                        S_CRCH_WAIT: begin
                            crc_rx[15:8] <= shf_data;
                            state        <= S_CRCL_START;
                        end
                        S_CRCL_WAIT: begin
                            crc_rx[7:0] <= shf_data;
                            state       <= S_CHECK;
                        end
                        default: begin
                            seq_busy <= 1'b0;
                            state    <= S_IDLE;
                        end
                    endcase
                end
            end else if (state == S_CHECK) begin
                if (crc_rx == crc_snap) begin
                    done <= 1'b1;
                end else begin
                    crc_err <= 1'b1;
                end
                seq_busy <= 1'b0;
                state    <= S_IDLE;
            end else begin
                seq_busy <= 1'b0;
                state    <= S_IDLE;
            end
        end
    end

    // FIFO storage; only written during DATA capture, never while full.
    always_ff @(posedge clk7) begin
        if (push) begin
            mem[wr_ptr] <= shf_data;
        end
    end

    // FIFO pointers, occupancy and the registered fall-through head.
    always_ff @(posedge clk7 or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
        end else begin
            rd_ptr <= rd_ptr_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            count    <= count_nxt;
            rd_valid <= (count_nxt != '0);
            rd_data  <= (count_nxt != '0) ? head_nxt : 8'h00;
        end
    end

endmodule

// File: tb/tb_spi_block_sequencer.sv
// Bench for spi_block_sequencer: a behavioural SPI shifter with random byte
// latency and CRC16-CCITT feeds queued byte streams; a host task drains the
// FIFO; expectations come from the queued block and its reference CRC.

module tb_spi_block_sequencer;

    localparam int BLOCK_LEN     = 512;
    localparam int FIFO_DEPTH    = 4;
    localparam int TOKEN_TIMEOUT = 4095;

    logic        clk7 = 1'b0;
    logic        rst;
    logic        go;
    logic        abort;
    logic        shf_start_read;
    logic        shf_busy;
    logic [7:0]  shf_data;
    logic        shf_crc_reset;
    logic [15:0] shf_crc;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ack;
    logic        seq_busy;
    logic        done;
    logic        crc_err;
    logic        token_err;
    logic        timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] rx_q  [$];
    logic [7:0] got_q [$];
    logic [7:0] blk   [$];

    int start_cnt   = 0;
    int crc_rst_cnt = 0;
    int lat_left    = 0;
    bit ack_en      = 1'b0;

    always #5 clk7 = ~clk7;

    spi_block_sequencer #(
        .BLOCK_LEN    (BLOCK_LEN),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .TOKEN_TIMEOUT(TOKEN_TIMEOUT)
    ) dut (
        .clk7          (clk7),
        .rst           (rst),
        .go            (go),
        .abort         (abort),
        .shf_start_read(shf_start_read),
        .shf_busy      (shf_busy),
        .shf_data      (shf_data),
        .shf_crc_reset (shf_crc_reset),
        .shf_crc       (shf_crc),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_ack        (rd_ack),
        .seq_busy      (seq_busy),
        .done          (done),
        .crc_err       (crc_err),
        .token_err     (token_err),
        .timeout_err   (timeout_err)
    );

    function automatic logic [15:0] crc16(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    function automatic logic [15:0] block_crc();
        logic [15:0] c;
        c = 16'h0000;
        foreach (blk[i]) c = crc16(c, blk[i]);
        return c;
    endfunction

    // Next byte off the wire (idle line reads 0xFF) together with updated CRC.
    function automatic logic [23:0] take_byte(input logic [15:0] c);
        logic [7:0] b;
        b = 8'hFF;
        if (rx_q.size() != 0) b = rx_q.pop_front();
        return {crc16(c, b), b};
    endfunction

    // Shifter model: start sampled at the edge, busy from the next cycle.
    always @(posedge clk7 or posedge rst) begin
        if (rst) begin
            shf_busy <= 1'b0;
            shf_data <= 8'h00;
            shf_crc  <= 16'h0000;
            lat_left <= 0;
        end else begin
            if (shf_crc_reset) begin
                shf_crc     <= 16'h0000;
                crc_rst_cnt <= crc_rst_cnt + 1;
            end
            if (shf_start_read) begin
                shf_busy  <= 1'b1;
                lat_left  <= $urandom_range(1, 3);
                start_cnt <= start_cnt + 1;
            end else if (shf_busy) begin
                if (lat_left <= 1) begin
                    shf_busy            <= 1'b0;
                    {shf_crc, shf_data} <= take_byte(shf_crc);
                end else begin
                    lat_left <= lat_left - 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step_host();
        @(negedge clk7);
        if (ack_en && rd_valid) begin
            got_q.push_back(rd_data);
            rd_ack = 1'b1;
        end else begin
            rd_ack = 1'b0;
        end
    endtask

    task automatic pulse_go();
        @(negedge clk7);
        rd_ack = 1'b0;
        go     = 1'b1;
        @(negedge clk7);
        go     = 1'b0;
    endtask

    task automatic run_to_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (seq_busy && n < budget) begin
            step_host();
            n++;
        end
        check({tag, "_idle"}, 32'(seq_busy), 32'd0);
        repeat (FIFO_DEPTH + 4) step_host();
    endtask

    task automatic new_block(input bit rand_data);
        blk.delete();
        for (int i = 0; i < BLOCK_LEN; i++) begin
            blk.push_back(rand_data ? 8'($urandom_range(0, 255)) : 8'(i % 256));
        end
    endtask

    task automatic load_stream(input int n_ff, input logic [15:0] crc_sent);
        rx_q.delete();
        repeat (n_ff) rx_q.push_back(8'hFF);
        rx_q.push_back(8'hFE);
        foreach (blk[i]) rx_q.push_back(blk[i]);
        rx_q.push_back(crc_sent[15:8]);
        rx_q.push_back(crc_sent[7:0]);
    endtask

    task automatic compare_prefix(input string tag, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= got_q.size() || got_q[i] !== blk[i]) bad++;
        end
        check({tag, "_count"}, 32'(got_q.size()), 32'(n));
        check({tag, "_order"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int          s0;
        int          c0;
        int          n_ff;
        bit          found;
        logic [15:0] good;
        logic [15:0] sent;
        logic [7:0]  bad_tok;

        rst    = 1'b1;
        go     = 1'b0;
        abort  = 1'b0;
        rd_ack = 1'b0;
        repeat (3) @(negedge clk7);
        check("rst_seq_busy", 32'(seq_busy), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_flags", 32'({done, crc_err, token_err, timeout_err}), 32'd0);
        check("rst_strobes", 32'({shf_start_read, shf_crc_reset}), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk7);

        // 1: FF,FF,FE, ramp data, correct CRC, host acks every cycle
        new_block(1'b0);
        good = block_crc();
        load_stream(2, good);
        got_q.delete();
        ack_en = 1'b1;
        s0 = start_cnt;
        c0 = crc_rst_cnt;
        pulse_go();
        run_to_idle("s1", 20000);
        compare_prefix("s1", BLOCK_LEN);
        check("s1_done", 32'(done), 32'd1);
        check("s1_crc_err", 32'(crc_err), 32'd0);
        check("s1_starts", 32'(start_cnt - s0), 32'(3 + BLOCK_LEN + 2));
        check("s1_crc_resets", 32'(crc_rst_cnt - c0), 32'd1);

        // 2: random data and token delay, last CRC byte inverted
        new_block(1'b1);
        good = block_crc();
        sent = good ^ 16'h00FF;
        n_ff = $urandom_range(0, 5);
        load_stream(n_ff, sent);
        got_q.delete();
        s0 = start_cnt;
        pulse_go();
        run_to_idle("s2", 20000);
        compare_prefix("s2", BLOCK_LEN);
        check("s2_done", 32'(done), 32'(sent == good));
        check("s2_crc_err", 32'(crc_err), 32'(sent != good));
        check("s2_starts", 32'(start_cnt - s0), 32'(n_ff + 1 + BLOCK_LEN + 2));

        // 3: line never leaves 0xFF
        rx_q.delete();
        got_q.delete();
        s0 = start_cnt;
        c0 = crc_rst_cnt;
        pulse_go();
        run_to_idle("s3", 40000);
        check("s3_timeout_err", 32'(timeout_err), 32'd1);
        check("s3_starts", 32'(start_cnt - s0), 32'(TOKEN_TIMEOUT));
        check("s3_rd_valid", 32'(rd_valid), 32'd0);
        check("s3_crc_resets", 32'(crc_rst_cnt - c0), 32'd0);
        check("s3_other_flags", 32'({done, crc_err, token_err}), 32'd0);

        // 4: illegal token byte
        bad_tok = 8'($urandom_range(0, 253));
        rx_q.delete();
        rx_q.push_back(bad_tok);
        s0 = start_cnt;
        c0 = crc_rst_cnt;
        pulse_go();
        run_to_idle("s4", 200);
        check("s4_token_err", 32'(token_err), 32'd1);
        check("s4_timeout_cleared", 32'(timeout_err), 32'd0);
        check("s4_starts", 32'(start_cnt - s0), 32'd1);
        check("s4_crc_resets", 32'(crc_rst_cnt - c0), 32'd0);

        // 5: host withholds rd_ack, FIFO fills and stalls the data phase
        new_block(1'b1);
        load_stream(0, block_crc());
        got_q.delete();
        ack_en = 1'b0;
        s0 = start_cnt;
        pulse_go();
        repeat (200) step_host();
        check("s5_stall_starts", 32'(start_cnt - s0), 32'(1 + FIFO_DEPTH));
        check("s5_stall_valid", 32'(rd_valid), 32'd1);
        check("s5_stall_head", 32'(rd_data), 32'(blk[0]));
        pulse_go();
        repeat (20) step_host();
        check("s5_go_ignored_busy", 32'(seq_busy), 32'd1);
        check("s5_go_ignored_starts", 32'(start_cnt - s0), 32'(1 + FIFO_DEPTH));
        ack_en = 1'b1;
        step_host();
        ack_en = 1'b0;
        repeat (50) step_host();
        check("s5_one_more_start", 32'(start_cnt - s0), 32'(2 + FIFO_DEPTH));
        ack_en = 1'b1;
        run_to_idle("s5", 20000);
        compare_prefix("s5", BLOCK_LEN);
        check("s5_done", 32'(done), 32'd1);

        // 6a: abort while the third data byte is on the wire
        new_block(1'b1);
        load_stream(0, block_crc());
        got_q.delete();
        ack_en = 1'b0;
        s0 = start_cnt;
        pulse_go();
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            step_host();
            if ((start_cnt - s0) >= 4 && shf_busy) found = 1'b1;
        end
        check("s6_reach_busy", 32'(found), 32'd1);
        abort = 1'b1;
        step_host();
        abort = 1'b0;
        repeat (10) step_host();
        check("s6_idle", 32'(seq_busy), 32'd0);
        check("s6_flags", 32'({done, crc_err, token_err, timeout_err}), 32'd0);
        check("s6_no_more_starts", 32'(start_cnt - s0), 32'd4);
        check("s6_fifo_kept", 32'(rd_valid), 32'd1);
        ack_en = 1'b1;
        repeat (8) step_host();
        compare_prefix("s6_kept", 2);
        check("s6_drained", 32'(rd_valid), 32'd0);

        // 6b: abort while stalled on a full FIFO, then restart flushes it
        new_block(1'b1);
        load_stream(0, block_crc());
        ack_en = 1'b0;
        pulse_go();
        repeat (100) step_host();
        abort = 1'b1;
        step_host();
        abort = 1'b0;
        step_host();
        check("s6b_idle", 32'(seq_busy), 32'd0);
        check("s6b_head_kept", 32'(rd_data), 32'(blk[0]));
        new_block(1'b1);
        load_stream($urandom_range(0, 3), block_crc());
        got_q.delete();
        ack_en = 1'b1;
        pulse_go();
        run_to_idle("s6b", 20000);
        compare_prefix("s6b", BLOCK_LEN);
        check("s6b_done", 32'(done), 32'd1);

        // 7: reset in the middle of a block
        new_block(1'b1);
        load_stream(1, block_crc());
        ack_en = 1'b0;
        pulse_go();
        repeat (30) step_host();
        @(negedge clk7);
        rst = 1'b1;
        @(negedge clk7);
        check("s7_rst_busy", 32'(seq_busy), 32'd0);
        check("s7_rst_valid", 32'(rd_valid), 32'd0);
        check("s7_rst_strobe", 32'(shf_start_read), 32'd0);
        rst = 1'b0;
        rx_q.delete();
        repeat (2) @(negedge clk7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
